sc_run_ctrl: RTL
================

SC_RUN_CTRL -- requirements
Module: sc_run_ctrl

Interface
REQ-001 SHALL have port mem_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port run_req, input, 1 bit: level; high requests free-running CPU clock.
REQ-004 SHALL have port step_req, input, 1 bit: level; each 0->1 transition requests one CPU cycle.
REQ-005 SHALL have port halt_req, input, 1 bit: level; highest-priority stop request.
REQ-006 SHALL have port cnt_clr, input, 1 bit: synchronous clear of cycle_cnt.
REQ-007 SHALL have port pc, input, 32 bits: current CPU program counter.
REQ-008 SHALL have port bp_addr, input, 32 bits: breakpoint address.
REQ-009 SHALL have port bp_en, input, 1 bit: breakpoint enable.
REQ-010 SHALL have port clock, output, 1 bit: registered CPU clock driven to the datapath.
REQ-011 SHALL have port halted, output, 1 bit: high while in HALT.
REQ-012 SHALL have port bp_hit, output, 1 bit: one-mem_clk pulse when halting on breakpoint.
REQ-013 SHALL have port cycle_cnt, output, 32 bits: count of CPU clock rising edges.

Function
REQ-014 SHALL implement states HALT, RUN, STEP_HI; clock changes only as listed below.
REQ-015 SHALL register step_req and detect a rising edge as step_req=1 with previous sample 0.
REQ-016 In HALT, clock SHALL be held 0; priority: halt_req -> stay; step edge -> STEP_HI with clock<=1; run_req -> RUN with clock held 0.
REQ-017 In STEP_HI, the next edge SHALL set clock<=0 and return to HALT; a step edge seen in STEP_HI SHALL be ignored.
REQ-018 In RUN with clock=1, the next edge SHALL set clock<=0 unconditionally (a started CPU cycle always completes).
REQ-019 In RUN with clock=0, the edge SHALL go to HALT (clock stays 0) if halt_req=1, run_req=0, or a breakpoint hit; otherwise clock<=1.
REQ-020 Breakpoint hit SHALL be pc==bp_addr and bp_en=1 and skip flag clear, evaluated only in RUN with clock=0.
REQ-021 Skip flag SHALL be set on every exit from HALT and cleared on the next clock rising edge, so resuming at a breakpoint executes one instruction.
REQ-022 bp_hit SHALL pulse for exactly the one mem_clk cycle following the edge that enters HALT due to breakpoint.
REQ-023 cycle_cnt SHALL increment by 1 on every edge that sets clock 0->1 and saturate at 32'hFFFFFFFF.
REQ-024 cnt_clr SHALL take priority over increment; a simultaneous rise leaves cycle_cnt=0.
REQ-025 Latency: run_req seen at HALT edge N -> RUN at N, first clock rise at edge N+1; RUN clock period = 2 mem_clk cycles.
REQ-026 halted SHALL be a direct decode of state (high iff HALT).

Reset
REQ-027 resetn=0 SHALL asynchronously force state=HALT, clock=0, bp_hit=0, cycle_cnt=0, skip flag=0, step_req sample=1 (no step from a level held through reset).
REQ-028 Reset asserted mid-cycle (clock=1) SHALL drop clock to 0 immediately; no counter increment results.

Configuration
REQ-029 Macro SC_RUN_CTRL_BP_EN defined: breakpoint logic per REQ-020..022 present.
REQ-030 Macro SC_RUN_CTRL_BP_EN undefined: bp_addr/bp_en ignored, no comparator or skip flag, bp_hit tied 0; all other behaviour identical.

Verification
REQ-031 Reset, run_req=1 for 10 mem_clk -> clock toggles 0,1,0,1 starting edge 2; cycle_cnt=5 after edge 10.
REQ-032 HALT, step_req 0->1 held 20 cycles -> exactly one clock pulse 1 mem_clk wide; cycle_cnt +1; halted back high after 2 edges.
REQ-033 RUN, halt_req asserted while clock=1 -> clock falls next edge, HALT on the following edge, no further rise.
REQ-034 bp_en=1, bp_addr=32'h0000000C, pc reaches 0xC -> HALT, bp_hit one pulse; run_req re-asserted -> one rise executes, pc leaves 0xC, no re-hit.
REQ-035 cycle_cnt preloaded near 32'hFFFFFFFF by running -> holds at FFFFFFFF; cnt_clr with simultaneous rise -> 0.
REQ-036 resetn pulled low while clock=1 in RUN -> clock=0, cycle_cnt=0, halted=1 without waiting for mem_clk.

Source files
------------

// File: rtl/sc_run_ctrl.sv
// CPU clock run/step/halt controller with saturating cycle counter.
// Optional breakpoint logic is built only when SC_RUN_CTRL_BP_EN is defined.
`timescale 1ns/1ps
module sc_run_ctrl (
  input  logic        mem_clk,
  input  logic        resetn,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        cnt_clr,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  output logic        clock,
  output logic        halted,
  output logic        bp_hit,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    S_HALT    = 2'd0,
    S_RUN     = 2'd1,
    S_STEP_HI = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        clock_q, clock_d;
  logic        step_prev_q;
  logic        step_edge;
  logic        bp_match;
  logic        bp_hit_d;
  logic        clk_rise;
  logic [31:0] cnt_q, cnt_d;

  assign step_edge = step_req && !step_prev_q;
  assign clk_rise  = !clock_q && clock_d;

  always_comb begin
    state_d  = state_q;
    clock_d  = clock_q;
    bp_hit_d = 1'b0;
    unique case (state_q)
      S_HALT: begin
        clock_d = 1'b0;
        if (halt_req) begin
          state_d = S_HALT;
        end else if (step_edge) begin
          state_d = S_STEP_HI;
          clock_d = 1'b1;
        end else if (run_req) begin
          state_d = S_RUN;
        end
      end
      S_STEP_HI: begin
        clock_d = 1'b0;
        state_d = S_HALT;
      end
      S_RUN: begin
        // A started CPU cycle always completes before any stop is honoured
        if (clock_q) begin
          clock_d = 1'b0;
        end else if (halt_req || !run_req || bp_match) begin
          state_d  = S_HALT;
          clock_d  = 1'b0;
          bp_hit_d = bp_match;
        end else begin
          clock_d = 1'b1;
        end
      end
      default: begin
        state_d = S_HALT;
        clock_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (clk_rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_HALT;
      clock_q     <= 1'b0;
      step_prev_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      clock_q     <= clock_d;
      step_prev_q <= step_req;
      cnt_q       <= cnt_d;
    end
  end

`ifdef SC_RUN_CTRL_BP_EN
  logic skip_q, skip_d;
  logic bp_hit_q;

  // Skip lets a resume from a breakpoint retire the instruction at bp_addr
  assign bp_match = bp_en && (pc == bp_addr) && !skip_q;

  always_comb begin
    skip_d = skip_q;
    if (clk_rise) begin
      skip_d = 1'b0;
    end
    if ((state_q == S_HALT) && (state_d != S_HALT)) begin
      skip_d = 1'b1;
    end
  end

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      skip_q   <= skip_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;

  assign bp_match  = 1'b0;
  assign unused_bp = ^{pc, bp_addr, bp_en, bp_hit_d};
  assign bp_hit    = 1'b0;
`endif

  assign clock     = clock_q;
  assign halted    = (state_q == S_HALT);
  assign cycle_cnt = cnt_q;

endmodule
